product_accumulator: RTL
========================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter W, default 64, SHALL set the width of the product and accumulator, matching the 64-bit signed multiplier output.
REQ-002 Parameter CW, default 8, SHALL set the width of the length field and beat counter.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  input  1  SHALL be the clock enable; when 0, all state, including the FSM, counter, accumulator and flags, SHALL hold.
REQ-006 start  input  1  SHALL request a new accumulation; it is sampled only in IDLE.
REQ-007 len  input  CW  SHALL give the number of products to sum, unsigned, sampled with start.
REQ-008 prod_valid  input  1  SHALL mean the upstream product is valid.
REQ-009 prod  input  W  SHALL carry the signed two's-complement product from the multiplier.
REQ-010 prod_ready  output  1  SHALL mean the block accepts a product this cycle.
REQ-011 acc_out  output  W  SHALL carry the signed accumulated sum, registered.
REQ-012 acc_valid  output  1  SHALL be a one-cycle pulse marking acc_out as final.
REQ-013 busy  output  1  SHALL be 1 in the ACCUM and DONE states.
REQ-014 ovf  output  1  SHALL be a sticky saturation flag for the current run.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and DONE, encoded in 2 bits.
REQ-016 In IDLE with en=1, start=1 and len!=0, the block SHALL load the counter with len, set acc_out to 0, clear ovf and move to ACCUM.
REQ-017 In IDLE with en=1, start=1 and len==0, the block SHALL set acc_out to 0, clear ovf and move to DONE.
REQ-018 prod_ready SHALL equal (state==ACCUM) AND en, and SHALL be combinational from state and en only.
REQ-019 A beat SHALL occur when prod_valid AND prod_ready are both 1; only on a beat SHALL acc_out update to sat(acc_out + prod) and the counter decrement.
REQ-020 The beat that takes the counter from 1 to 0 SHALL move the FSM to DONE on the same edge, so DONE follows the last beat by one cycle.
REQ-021 prod_valid=0 in ACCUM SHALL hold all state, with no timeout.
REQ-022 In DONE with en=1, acc_valid SHALL be 1 for exactly that cycle, and the FSM SHALL move to IDLE on the next edge.
REQ-023 In DONE with en=0, the FSM SHALL stay in DONE and acc_valid SHALL stay 1 until en returns.
REQ-024 The sum SHALL be computed at W+1 bits; if the result exceeds 2^(W-1)-1, acc_out SHALL become 0x7FFF_FFFF_FFFF_FFFF and ovf SHALL be set to 1.
REQ-025 If the W+1-bit sum is below -2^(W-1), acc_out SHALL become 0x8000_0000_0000_0000 and ovf SHALL be set to 1.
REQ-026 After saturation, later beats SHALL continue to accumulate from the clamped value.
REQ-027 start while busy SHALL be ignored, with no restart and no effect on the counter.
REQ-028 acc_out and ovf SHALL hold their last values in IDLE until the next accepted start.
REQ-029 A product whose value is exactly 0 SHALL still count as a beat.

Reset
REQ-030 While reset=0, asynchronously: state=IDLE, counter=0, acc_out=0, acc_valid=0, ovf=0, and therefore busy=0 and prod_ready=0.
REQ-031 Reset asserted mid-ACCUM SHALL abandon the run without an acc_valid pulse; after release the block SHALL wait in IDLE for start.
REQ-032 Deassertion SHALL take effect at the first rising clk edge after reset goes high; no sync stage is required inside the block.

Verification
REQ-033 len=3, products 5, -2, 7 back-to-back with prod_valid=1 -> acc_valid pulses 1 cycle after the 3rd beat; acc_out=10; ovf=0.
REQ-034 len=2, products 0x7FFF_FFFF_FFFF_FFFF and 1 -> acc_out=0x7FFF_FFFF_FFFF_FFFF; ovf=1. A following run with len=2 and products -4, -4 -> acc_out=0xFFFF_FFFF_FFFF_FFF8 (-8); ovf=0.
REQ-035 len=4 with prod_valid toggling 1,0,1,0,... and products all -1 -> exactly 4 beats counted; acc_out=0xFFFF_FFFF_FFFF_FFFC; start pulsed mid-run has no effect.
REQ-036 len=0 with start -> DONE the next cycle; acc_valid pulse; acc_out=0.
REQ-037 len=3 run with en=0 for 5 cycles after the 1st beat -> prod_ready=0 and no state change during the stall; final acc_out equals the sum of the 3 products.
REQ-038 reset driven low after 2 beats of a len=4 run, then released -> all outputs 0, state IDLE, no acc_valid; a new len=1 run with product 9 -> acc_out=9.

Source files
------------

// File: rtl/product_accumulator.sv
// Length-counted accumulator that sums a stream of signed products with
// saturation, and reports the final sum with a one-cycle valid pulse.
module product_accumulator #(
   parameter int W  = 64,
   parameter int CW = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                start,
   input  logic [CW-1:0]       len,
   input  logic                prod_valid,
   input  logic signed [W-1:0] prod,
   output logic                prod_ready,
   output logic signed [W-1:0] acc_out,
   output logic                acc_valid,
   output logic                busy,
   output logic                ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACCUM = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_nxt;
   logic signed [W-1:0] acc_nxt;
   logic                ovf_nxt;
   logic                beat;
   logic signed [W:0]   sum_wide;

   // Sign-extended add; one extra bit keeps the true sum of two W-bit values.
   function automatic logic signed [W:0] add_wide(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
      return {a[W-1], a} + {b[W-1], b};
   endfunction

   // The top two bits disagree exactly when the sum left the W-bit range.
   function automatic logic sum_overflows(input logic signed [W:0] s);
      return s[W] ^ s[W-1];
   endfunction

   function automatic logic signed [W-1:0] sat(input logic signed [W:0] s);
      if (sum_overflows(s))
         return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      return s[W-1:0];
   endfunction

   assign prod_ready = (state == ACCUM) && en;
   assign beat       = prod_valid && prod_ready;
   assign acc_valid  = (state == DONE);
   assign busy       = (state == ACCUM) || (state == DONE);
   assign sum_wide   = add_wide(acc_out, prod);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      acc_nxt   = acc_out;
      ovf_nxt   = ovf;
      case (state)
         IDLE: begin
            if (start) begin
               acc_nxt = '0;
               ovf_nxt = 1'b0;
               if (len != '0) begin
                  cnt_nxt   = len;
                  state_nxt = ACCUM;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         ACCUM: begin
            if (beat) begin
               acc_nxt = sat(sum_wide);
               if (sum_overflows(sum_wide))
                  ovf_nxt = 1'b1;
               cnt_nxt = cnt - CW'(1);
               if (cnt == CW'(1))
                  state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // en low freezes every register, so a DONE stall keeps acc_valid high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         acc_out <= '0;
         ovf     <= 1'b0;
      end else if (en) begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         acc_out <= acc_nxt;
         ovf     <= ovf_nxt;
      end
   end

endmodule
